// File: rtl/linebuf_pkg.sv
// Shared types and constants for the 9x9 line-buffer window generator.
// The window_t type is also consumed by the downstream inner-product stage.
package linebuf_pkg;

  localparam int unsigned K         = 9;      // window edge
  localparam int unsigned WIN_N     = K * K;  // window element count
  localparam int unsigned DEF_PIX_W = 7;      // default pixel width

  typedef logic [DEF_PIX_W-1:0] pix_t;
  typedef pix_t window_t [0:WIN_N-1];

endpackage : linebuf_pkg

// File: rtl/linebuf_window9x9_line_mem.sv
// Single line memory, DEPTH entries of W bits.
// The read is asynchronous, so in the same cycle the old word is returned while
// the new word is written at the same address.
// Ports:
//   clk      - clock
//   we_i     - write enable (accepted pixel)
//   addr_i   - column address
//   wdata_i  - word written at addr_i
//   rdata_c  - word currently stored at addr_i (combinational)
module line_mem #(
  parameter int unsigned DEPTH = 28,
  parameter int unsigned W     = 7,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_c
);

  logic [W-1:0] mem_q [0:DEPTH-1];

  // Storage only; its contents after reset do not matter.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_c = mem_q[addr_i];

endmodule : line_mem

// File: rtl/linebuf_window9x9.sv
// Streaming line buffer and 9x9 window generator for a raster pixel stream.
// Eight line memories hold the previous lines; a 9x9 register window shifts
// left on every accepted pixel. win_valid flags each fully-inside window.
// Optional build macro: LINEBUF_STRIDE2_EN - only windows whose origin
// (row-8, col-8) has both coordinates even are flagged.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   pix_in      - input pixel, raster order
//   pix_valid   - pixel qualifier; low stalls the block
//   sof         - start of frame, sampled with pix_valid
//   xarray      - window, row-major xarray[r*9+c]; [0] oldest, [80] newest
//   win_valid   - one-cycle pulse: xarray holds a complete window
//   frame_done  - one-cycle pulse after the last pixel of a frame
module linebuf_window9x9
  import linebuf_pkg::*;
#(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned PIX_W = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  output logic [PIX_W-1:0] xarray [0:WIN_N-1],
  output logic             win_valid,
  output logic             frame_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned NL = K - 1;  // stored previous lines

  logic [CW-1:0]    col_q, col_d, cur_col_c;
  logic [RW-1:0]    row_q, row_d, cur_row_c;
  logic             last_col_c, last_pix_c;
  logic             win_valid_q, win_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [PIX_W-1:0] xarray_q [0:WIN_N-1];
  logic [PIX_W-1:0] xarray_d [0:WIN_N-1];
  logic [PIX_W-1:0] lm_rd [0:NL-1];
  logic [PIX_W-1:0] lm_wd [0:NL-1];

  // Coordinates of the pixel being accepted; sof forces it to (0,0).
  assign cur_col_c  = sof ? '0 : col_q;
  assign cur_row_c  = sof ? '0 : row_q;
  assign last_col_c = (cur_col_c == CW'(IMG_W - 1));
  assign last_pix_c = last_col_c && (cur_row_c == RW'(IMG_H - 1));

  // Line memory chain: line 0 takes the new pixel, line k takes line k-1's old word.
  for (genvar k = 0; k < NL; k++) begin : g_line
    if (k == 0) begin : g_head
      assign lm_wd[k] = pix_in;
    end else begin : g_tail
      assign lm_wd[k] = lm_rd[k-1];
    end
    line_mem #(
      .DEPTH (IMG_W),
      .W     (PIX_W),
      .AW    (CW)
    ) u_line_mem (
      .clk     (clk),
      .we_i    (pix_valid),
      .addr_i  (cur_col_c),
      .wdata_i (lm_wd[k]),
      .rdata_c (lm_rd[k])
    );
  end

  // Counters, window shift and pulse generation.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    xarray_d     = xarray_q;

    if (pix_valid) begin
      if (last_col_c) begin
        col_d = '0;
        row_d = (cur_row_c == RW'(IMG_H - 1)) ? '0 : cur_row_c + RW'(1);
      end else begin
        col_d = cur_col_c + CW'(1);
        row_d = cur_row_c;
      end

      win_valid_d = (cur_row_c >= RW'(K - 1)) && (cur_col_c >= CW'(K - 1));
`ifdef LINEBUF_STRIDE2_EN
      // K-1 is even, so origin parity equals current-coordinate parity.
      win_valid_d = win_valid_d && !cur_row_c[0] && !cur_col_c[0];
`endif
      frame_done_d = last_pix_c && !sof;

      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          xarray_d[r*K + c] = xarray_q[r*K + c + 1];
        end
      end
      // Window row r (r<8) is fed by line memory 7-r; the bottom row by the new pixel.
      for (int r = 0; r < K - 1; r++) begin
        xarray_d[r*K + K - 1] = lm_rd[NL - 1 - r];
      end
      xarray_d[WIN_N - 1] = pix_in;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < WIN_N; i++) xarray_q[i] <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      xarray_q     <= xarray_d;
    end
  end

  assign xarray     = xarray_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule : linebuf_window9x9

// File: tb/tb_linebuf_window9x9.sv
// Directed bench for linebuf_window9x9: every window is compared against a
// 9x9 crop of the frame the bench sent; pulses are checked on every cycle.
module tb_linebuf_window9x9;

  localparam int W  = 28;
  localparam int H  = 28;
  localparam int VW = 81 * 7;
`ifdef LINEBUF_STRIDE2_EN
  localparam int EXP_WIN = 100;
`else
  localparam int EXP_WIN = 400;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       sof = 1'b0;
  logic [6:0] xarray [0:80];
  logic       win_valid;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int win_cnt;
  int fd_cnt;
  logic [6:0] img [0:H-1][0:W-1];

  linebuf_window9x9 #(.IMG_W(W), .IMG_H(H), .PIX_W(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .sof        (sof),
    .xarray     (xarray),
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack_win();
    logic [VW-1:0] v;
    for (int i = 0; i < 81; i++) v[i*7 +: 7] = xarray[i];
    return v;
  endfunction

  function automatic logic [VW-1:0] crop(input int r, input int c);
    logic [VW-1:0] v;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 9; j++)
        v[(i*9+j)*7 +: 7] = img[r-8+i][c-8+j];
    return v;
  endfunction

  // One accepted pixel at frame coordinate (r,c); outputs checked after the edge.
  task automatic send_pix(input int r, input int c, input logic [6:0] v, input logic s,
                          input bit chk_first);
    logic exp_wv;
    img[r][c] = v;
    pix_in    = v;
    pix_valid = 1'b1;
    sof       = s;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
    exp_wv = (r >= 8) && (c >= 8);
`ifdef LINEBUF_STRIDE2_EN
    exp_wv = exp_wv && ((r - 8) % 2 == 0) && ((c - 8) % 2 == 0);
`endif
    check("win_valid", VW'(win_valid), VW'(exp_wv));
    check("frame_done", VW'(frame_done), VW'((r == H-1) && (c == W-1)));
    if (exp_wv) begin
      check("window", pack_win(), crop(r, c));
      if (chk_first && win_cnt == 0) begin
        check("first_x0",  VW'(xarray[0]),  VW'(0));
        check("first_x8",  VW'(xarray[8]),  VW'(8));
        check("first_x72", VW'(xarray[72]), VW'(96));
        check("first_x80", VW'(xarray[80]), VW'(104));
      end
`ifdef LINEBUF_STRIDE2_EN
      if (chk_first && win_cnt == 1) check("second_x0", VW'(xarray[0]), VW'(2));
`endif
    end
    if (win_valid)  win_cnt++;
    if (frame_done) fd_cnt++;
  endtask

  task automatic stall_cycle();
    pix_valid = 1'b0;
    pix_in    = 7'h55;
    @(posedge clk);
    #1;
    check("stall_win_valid", VW'(win_valid), VW'(0));
    check("stall_frame_done", VW'(frame_done), VW'(0));
  endtask

  // Send a frame from (0,0), stopping before (stop_r, stop_c).
  task automatic run_frame(input int base, input bit sof0, input bit gaps,
                           input int stop_r, input int stop_c, input bit chk_first);
    win_cnt = 0;
    fd_cnt  = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        if (gaps) while ($urandom_range(99, 0) < 30) stall_cycle();
        send_pix(r, c, 7'((r*W + c + base) % 128), sof0 && r == 0 && c == 0, chk_first);
      end
    end
  endtask

  initial begin
    #12;
    check("rst_win_valid", VW'(win_valid), VW'(0));
    check("rst_frame_done", VW'(frame_done), VW'(0));
    check("rst_xarray", pack_win(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Gap-free frame starting with sof.
    run_frame(0, 1'b1, 1'b0, H, 0, 1'b1);
    check("frameA_windows", VW'(win_cnt), VW'(EXP_WIN));
    check("frameA_done", VW'(fd_cnt), VW'(1));

    // Same pattern with random stalls, no sof (counters wrapped).
    run_frame(0, 1'b0, 1'b1, H, 0, 1'b1);
    check("frameB_windows", VW'(win_cnt), VW'(EXP_WIN));
    check("frameB_done", VW'(fd_cnt), VW'(1));

    // Partial frame cut by sof at (15,3); new frame uses different data.
    run_frame(37, 1'b0, 1'b0, 15, 3, 1'b0);
    check("frameC_partial_done", VW'(fd_cnt), VW'(0));
    run_frame(61, 1'b1, 1'b0, H, 0, 1'b0);
    check("frameD_windows", VW'(win_cnt), VW'(EXP_WIN));
    check("frameD_done", VW'(fd_cnt), VW'(1));

    // Reset mid-frame: outputs clear without a clock edge.
    run_frame(0, 1'b0, 1'b0, 12, 5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_xarray", pack_win(), '0);
    check("midrst_win_valid", VW'(win_valid), VW'(0));
    check("midrst_frame_done", VW'(frame_done), VW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 1'b0, 1'b0, H, 0, 1'b1);
    check("frameE_windows", VW'(win_cnt), VW'(EXP_WIN));
    check("frameE_done", VW'(fd_cnt), VW'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_linebuf_window9x9
